serial_subtractor_64bit: RTL and testbench

Multi-cycle unsigned subtractor, the inverse arithmetic path to the team's 64-bit ripple adder. Computes Diff = A - B - Bin with a borrow chain, processing DIGIT bits per clock LSB-first.
- Trades latency for area: one DIGIT-wide borrow slice is reused across cycles.
- Sits in the datapath behind a valid/ready handshake on both input and output.

---
 rtl/serial_subtractor_64bit.sv | 150 +++++++++++++++
 tb/tb_serial_subtractor_64bit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_64bit.sv
// Digit-serial unsigned subtractor: Diff = A - B - Bin, DIGIT bits per clock, LSB first.
// Optional signed-overflow output Vout is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_64bit #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             out_valid,
`ifdef SUB_OVERFLOW_EN
   output logic             Vout,
`endif
   input  logic             out_ready
);

   localparam int unsigned N    = WIDTH / DIGIT;
   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("serial_subtractor_64bit: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SUB_OVERFLOW_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             vout_q, vout_d;
`endif

   // One DIGIT-wide borrow slice; the extra top bit is the borrow out of this digit.
   logic [DIGIT-1:0] chunk;
   logic             borrow_n;
   assign {borrow_n, chunk} = {1'b0, a_q[DIGIT-1:0]}
                            - {1'b0, b_q[DIGIT-1:0]}
                            - (DIGIT+1)'(borrow_q);

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign Diff      = diff_q;
   assign Bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
   assign Vout      = vout_q;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;
`ifdef SUB_OVERFLOW_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      vout_d   = vout_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = A;
               b_d      = B;
               borrow_d = Bin;
               cnt_d    = '0;
               state_d  = RUN;
`ifdef SUB_OVERFLOW_EN
               a_msb_d  = A[WIDTH-1];
               b_msb_d  = B[WIDTH-1];
`endif
            end
         end
         RUN: begin
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            res_d    = {chunk, res_q[WIDTH-1:DIGIT]};
            borrow_d = borrow_n;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               diff_d  = {chunk, res_q[WIDTH-1:DIGIT]};
               bout_d  = borrow_n;
               state_d = DONE;
`ifdef SUB_OVERFLOW_EN
               vout_d  = (a_msb_q ^ b_msb_q) & (chunk[DIGIT-1] ^ a_msb_q);
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SUB_OVERFLOW_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         vout_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
`ifdef SUB_OVERFLOW_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         vout_q   <= vout_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor_64bit.sv
// Scoreboard bench for serial_subtractor_64bit: driver pushes expected results, monitor pops on out_valid.
// Vout is checked only when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_64bit;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned DIGIT = 4;
   localparam int unsigned N     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] A, B;
   logic             Bin;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
   logic             out_valid;
   logic             out_ready;
   logic             vout_w;

   serial_subtractor_64bit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Diff      (Diff),
      .Bout      (Bout),
      .out_valid (out_valid),
`ifdef SUB_OVERFLOW_EN
      .Vout      (vout_w),
`endif
      .out_ready (out_ready)
   );
`ifndef SUB_OVERFLOW_EN
   assign vout_w = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             vout;
      int               acc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Driver: called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                       input logic push, input logic [WIDTH-1:0] ed, input logic eb, input logic ev);
      exp_t e;
      int   guard;
      A = a; B = b; Bin = bin; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         fails++;
         $display("FAIL accept_timeout: in_ready never rose");
      end else if (push) begin
         e.diff = ed; e.bout = eb; e.vout = ev; e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      chk("ready_after_done", 64'(in_ready), 64'd1);
      chk("valid_after_done", 64'(out_valid), 64'd0);
   endtask

   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        output logic [WIDTH-1:0] d, output logic bo, output logic vo);
      d  = a - b - WIDTH'(bin);
      bo = ({1'b0, a} < ({1'b0, b} + (WIDTH+1)'(bin)));
      vo = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
   endtask

   // Monitor: checks every cycle out_valid is high, pops on transfer.
   initial begin : monitor
      exp_t e;
      logic seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out_valid: got Diff=%h Bout=%b, expected no output", Diff, Bout);
            end else begin
               e = q[0];
               if (!seen) chk("latency", 64'(cyc - e.acc), 64'(N));
               seen = 1'b1;
               chk("Diff", Diff, e.diff);
               chk("Bout", 64'(Bout), 64'(e.bout));
`ifdef SUB_OVERFLOW_EN
               chk("Vout", 64'(vout_w), 64'(e.vout));
`endif
               chk("in_ready_in_done", 64'(in_ready), 64'd0);
               if (out_ready) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   logic [WIDTH-1:0] da[8], db[8], ed[8];
   logic             dbin[8], eb[8], ev[8];

   initial begin : main
      logic [WIDTH-1:0] ra, rb, rd;
      logic             rbin, rbo, rvo;

      da[0] = 64'd5;                    db[0] = 64'd3;                    dbin[0] = 1'b0;
      ed[0] = 64'd2;                    eb[0] = 1'b0; ev[0] = 1'b0;
      da[1] = 64'd0;                    db[1] = 64'd1;                    dbin[1] = 1'b0;
      ed[1] = 64'hFFFF_FFFF_FFFF_FFFF;  eb[1] = 1'b1; ev[1] = 1'b0;
      da[2] = 64'd0;                    db[2] = 64'd0;                    dbin[2] = 1'b1;
      ed[2] = 64'hFFFF_FFFF_FFFF_FFFF;  eb[2] = 1'b1; ev[2] = 1'b0;
      da[3] = 64'hFFFF_FFFF_FFFF_FFFF;  db[3] = 64'h0123_4567_89AB_CDEF;  dbin[3] = 1'b1;
      ed[3] = 64'hFEDC_BA98_7654_320F;  eb[3] = 1'b0; ev[3] = 1'b0;
      da[4] = 64'h8000_0000_0000_0000;  db[4] = 64'd1;                    dbin[4] = 1'b0;
      ed[4] = 64'h7FFF_FFFF_FFFF_FFFF;  eb[4] = 1'b0; ev[4] = 1'b1;
      da[5] = 64'hDEAD_BEEF_CAFE_F00D;  db[5] = 64'hDEAD_BEEF_CAFE_F00D;  dbin[5] = 1'b0;
      ed[5] = 64'd0;                    eb[5] = 1'b0; ev[5] = 1'b0;
      da[6] = 64'd1;                    db[6] = 64'd2;                    dbin[6] = 1'b1;
      ed[6] = 64'hFFFF_FFFF_FFFF_FFFE;  eb[6] = 1'b1; ev[6] = 1'b0;
      da[7] = 64'h7FFF_FFFF_FFFF_FFFF;  db[7] = 64'hFFFF_FFFF_FFFF_FFFF;  dbin[7] = 1'b0;
      ed[7] = 64'h8000_0000_0000_0000;  eb[7] = 1'b1; ev[7] = 1'b1;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_Diff", Diff, 64'd0);
      chk("rst_Bout", 64'(Bout), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Directed vectors, one at a time.
      for (int i = 0; i < 8; i++) begin
         send(da[i], db[i], dbin[i], 1'b1, ed[i], eb[i], ev[i]);
         chk("in_ready_drop", 64'(in_ready), 64'd0);
         drain();
      end

      // Back-pressure: hold result for 5 cycles while a spurious in_valid is presented.
      out_ready = 1'b0;
      send(64'h0000_0000_0000_1000, 64'h0000_0000_0000_0001, 1'b0, 1'b1,
           64'h0000_0000_0000_0FFF, 1'b0, 1'b0);
      for (int g = 0; g < 40 && !out_valid; g++) begin
         @(posedge clk); #1;
      end
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      A = 64'h1111_2222_3333_4444; B = 64'h5; Bin = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      chk("bp_single_transfer", 64'(out_valid), 64'd0);
      chk("bp_queue_empty", 64'(q.size()), 64'd0);
      chk("bp_ready_after", 64'(in_ready), 64'd1);

      // Reset in the 8th RUN cycle aborts the operation.
      send(64'd100, 64'd7, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_run_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("abort_Diff", Diff, 64'd0);
      chk("abort_Bout", 64'(Bout), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      repeat (20) @(posedge clk);
      #1;
      send(64'd100, 64'd7, 1'b0, 1'b1, 64'd93, 1'b0, 1'b0);
      drain();

      // Random triples checked against a behavioural model, issued back to back.
      for (int r = 0; r < 1000; r++) begin
         ra   = {$urandom, $urandom};
         rb   = (r % 4 == 0) ? ra : {$urandom, $urandom};
         rbin = 1'($urandom_range(0, 1));
         model(ra, rb, rbin, rd, rbo, rvo);
         send(ra, rb, rbin, 1'b1, rd, rbo, rvo);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
